// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with optional skid entry: LANES slots of DATA_W bits
// moved as one bundle with valid/ready, flush and stall.
module pipe_skid_reg #(
   parameter int unsigned DATA_W = 32'd64,
   parameter int unsigned LANES  = 32'd1,
   parameter int unsigned SKID   = 32'd1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      stall_i,
   input  logic [LANES-1:0]          up_valid_i,
   input  logic [LANES*DATA_W-1:0]   up_data_i,
   output logic                      up_ready_o,
   output logic [LANES-1:0]          dn_valid_o,
   output logic [LANES*DATA_W-1:0]   dn_data_o,
   input  logic                      dn_ready_i,
   output logic [1:0]                occ_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [LANES-1:0]          main_v_q, main_v_d;
   logic [LANES*DATA_W-1:0]   main_d_q, main_d_d;
   logic [LANES-1:0]          skid_v_q, skid_v_d;
   logic [LANES*DATA_W-1:0]   skid_d_q, skid_d_d;
   logic                      rdy_q, rdy_d;

   logic [LANES*DATA_W-1:0]   in_data;
   logic                      ready_comb;
   logic                      in_fire;
   logic                      out_fire;

   // Idle lanes are captured as zero so downstream never sees stale payload.
   always_comb begin
      in_data = '0;
      for (int unsigned k = 32'd0; k < LANES; k++) begin
         if (up_valid_i[k]) begin
            in_data[k*DATA_W +: DATA_W] = up_data_i[k*DATA_W +: DATA_W];
         end else begin
            in_data[k*DATA_W +: DATA_W] = '0;
         end
      end
   end

   assign ready_comb = (state_q == ST_EMPTY) | (dn_ready_i & ~stall_i);
   assign up_ready_o = (SKID != 32'd0) ? rdy_q : ready_comb;
   assign in_fire    = (|up_valid_i) & up_ready_o;
   assign out_fire   = (|main_v_q) & dn_ready_i & ~stall_i;

   // Next-state logic: flush empties everything; otherwise FIFO-ordered main/skid moves.
   always_comb begin
      state_d  = state_q;
      main_v_d = main_v_q;
      main_d_d = main_d_q;
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      if (flush_i) begin
         state_d  = ST_EMPTY;
         main_v_d = '0;
         main_d_d = '0;
         skid_v_d = '0;
         skid_d_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d  = ST_ONE;
                  main_v_d = up_valid_i;
                  main_d_d = in_data;
               end else begin
                  state_d  = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_v_d = up_valid_i;
                  main_d_d = in_data;
               end else if (in_fire && (SKID != 32'd0)) begin
                  state_d  = ST_TWO;
                  skid_v_d = up_valid_i;
                  skid_d_d = in_data;
               end else if (out_fire) begin
                  state_d  = ST_EMPTY;
                  main_v_d = '0;
                  main_d_d = '0;
               end else begin
                  state_d  = ST_ONE;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d  = ST_ONE;
                  main_v_d = skid_v_q;
                  main_d_d = skid_d_q;
                  skid_v_d = '0;
                  skid_d_d = '0;
               end else begin
                  state_d  = ST_TWO;
               end
            end
            default: begin
               state_d  = ST_EMPTY;
               main_v_d = '0;
               main_d_d = '0;
               skid_v_d = '0;
               skid_d_d = '0;
            end
         endcase
      end
      rdy_d = (state_d != ST_TWO);
   end

   // State and payload registers; ready is a flop so it never sees dn_ready_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_EMPTY;
         main_v_q <= '0;
         main_d_q <= '0;
         skid_v_q <= '0;
         skid_d_q <= '0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         main_v_q <= main_v_d;
         main_d_q <= main_d_d;
         skid_v_q <= skid_v_d;
         skid_d_q <= skid_d_d;
         rdy_q    <= rdy_d;
      end
   end

   assign dn_valid_o = main_v_q;
   assign dn_data_o  = main_d_q;
   assign occ_o      = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: SKID=1 and SKID=0 instances (LANES=2) driven with shared
// stimulus and each checked against a bounded-queue reference model.
module tb_pipe_skid_reg;
   localparam int DW = 32;
   localparam int LN = 2;

   typedef struct packed {
      logic [LN-1:0]    v;
      logic [LN*DW-1:0] d;
   } bundle_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, flush, stall, dn_rdy;
   logic [LN-1:0]    up_v;
   logic [LN*DW-1:0] up_d;
   logic             rdy1, rdy0;
   logic [LN-1:0]    v1, v0;
   logic [LN*DW-1:0] d1, d0;
   logic [1:0]       occ1, occ0;

   bundle_t q1[$];
   bundle_t q0[$];
   int errs   = 0;
   int checks = 0;

   pipe_skid_reg #(.DATA_W(DW), .LANES(LN), .SKID(1)) u_skid (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
      .up_valid_i(up_v), .up_data_i(up_d), .up_ready_o(rdy1),
      .dn_valid_o(v1), .dn_data_o(d1), .dn_ready_i(dn_rdy), .occ_o(occ1));

   pipe_skid_reg #(.DATA_W(DW), .LANES(LN), .SKID(0)) u_flat (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
      .up_valid_i(up_v), .up_data_i(up_d), .up_ready_o(rdy0),
      .dn_valid_o(v0), .dn_data_o(d0), .dn_ready_i(dn_rdy), .occ_o(occ0));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bundle register modelled as a FIFO of capacity 2 (skid) or 1 (flat).
   task automatic step_model(ref bundle_t q[$], input bit skid);
      bit      ready, outf, inf;
      bundle_t b;
      ready = skid ? (q.size() < 2) : ((q.size() == 0) || (dn_rdy && !stall));
      if (rst || flush) begin
         q.delete();
      end else begin
         outf = (q.size() > 0) && dn_rdy && !stall;
         inf  = (|up_v) && ready;
         b.v  = up_v;
         for (int k = 0; k < LN; k++) b.d[k*DW +: DW] = up_v[k] ? up_d[k*DW +: DW] : '0;
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(b);
      end
   endtask

   task automatic compare_all();
      bundle_t e1, e0;
      e1 = (q1.size() > 0) ? q1[0] : '0;
      e0 = (q0.size() > 0) ? q0[0] : '0;
      check_val("skid_valid", 64'(v1), 64'(e1.v));
      check_val("skid_data", 64'(d1), 64'(e1.d));
      check_val("skid_occ", 64'(occ1), 64'(q1.size()));
      check_val("skid_ready", 64'(rdy1), 64'(q1.size() < 2));
      check_val("flat_valid", 64'(v0), 64'(e0.v));
      check_val("flat_data", 64'(d0), 64'(e0.d));
      check_val("flat_occ", 64'(occ0), 64'(q0.size()));
      check_val("flat_ready", 64'(rdy0), 64'((q0.size() == 0) || (dn_rdy && !stall)));
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      step_model(q1, 1'b1);
      step_model(q0, 1'b0);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; dn_rdy = 1'b1;
      up_v = 2'b11; up_d = {32'h1111_1111, 32'h2222_2222};
      @(posedge clk);
      step_model(q1, 1'b1);
      step_model(q0, 1'b0);
      #1;
      rst = 1'b0; up_v = 2'b00;
      check_val("rst_occ", 64'(occ1), 64'd0);
      check_val("rst_valid", 64'(v1), 64'd0);
      check_val("rst_ready", 64'(rdy1), 64'd1);
      cycle();

      // back-to-back stream
      up_v = 2'b11;
      up_d = {32'hB, 32'hA}; cycle();
      check_val("stream_valid", 64'(v1), 64'd3);
      check_val("stream_occ", 64'(occ1), 64'd1);
      up_d = {32'hD, 32'hC}; cycle();
      check_val("stream_data2", 64'(d1), {32'hD, 32'hC});
      up_d = {32'hF, 32'hE}; cycle();
      up_v = 2'b00; cycle(); cycle();

      // fill skid, hold off Z, then drain in order
      dn_rdy = 1'b0; up_v = 2'b11;
      up_d = {32'h1, 32'hAAAA}; cycle();
      up_d = {32'h2, 32'hBBBB}; cycle();
      check_val("skid_full_occ", 64'(occ1), 64'd2);
      check_val("skid_full_rdy", 64'(rdy1), 64'd0);
      up_d = {32'h3, 32'hCCCC}; cycle();
      dn_rdy = 1'b1; cycle();
      check_val("drain_y", 64'(d1), {32'h2, 32'hBBBB});
      cycle();
      check_val("drain_z", 64'(d1), {32'h3, 32'hCCCC});
      up_v = 2'b00; cycle(); cycle(); cycle();

      // flush while full, with W offered
      dn_rdy = 1'b0; up_v = 2'b11;
      up_d = {32'h5, 32'h4}; cycle();
      up_d = {32'h7, 32'h6}; cycle();
      flush = 1'b1; up_d = {32'h9, 32'h8}; cycle();
      check_val("flush_occ", 64'(occ1), 64'd0);
      check_val("flush_valid", 64'(v1), 64'd0);
      flush = 1'b0; up_v = 2'b00; dn_rdy = 1'b1; cycle(); cycle(); cycle();

      // partial lane
      up_v = 2'b01; up_d = {32'hDEAD, 32'h1234}; cycle();
      check_val("partial_valid", 64'(v1), 64'd1);
      check_val("partial_lane1", 64'(d1[63:32]), 64'd0);
      up_v = 2'b00; cycle();

      // continuous input with toggling downstream ready
      up_v = 2'b11;
      for (int i = 0; i < 20; i++) begin
         dn_rdy = (i % 2 == 0);
         up_d = {$urandom, $urandom};
         cycle();
      end

      // random traffic with stall, flush and reset
      for (int i = 0; i < 600; i++) begin
         up_v   = 2'($urandom);
         up_d   = {$urandom, $urandom};
         dn_rdy = ($urandom_range(0, 3) != 0);
         stall  = ($urandom_range(0, 5) == 0);
         flush  = ($urandom_range(0, 19) == 0);
         rst    = ($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 1'b0; flush = 1'b0; stall = 1'b0; up_v = 2'b00; dn_rdy = 1'b1;
      cycle(); cycle(); cycle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
